paddle_bbox_tracker: RTL
========================

PADDLE_BBOX_TRACKER -- requirements
Module: paddle_bbox_tracker

Interface
REQ-001 SHALL provide parameter IMG_W, default 640, active image width in pixels.
REQ-002 SHALL provide parameter IMG_H, default 480, active image height in pixels.
REQ-003 SHALL provide parameter MIN_PIXELS, default 64, minimum matching-pixel count for a valid paddle.
REQ-004 SHALL provide port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL provide port pixel_valid  input  1  qualifies pixel_x/pixel_y/pixel_match this cycle.
REQ-007 SHALL provide ports pixel_x, pixel_y  input  13 each  unsigned pixel coordinates.
REQ-008 SHALL provide port pixel_match  input  1  pixel passed the paddle colour threshold.
REQ-009 SHALL provide port frame_end  input  1  one-cycle pulse after the last pixel of a frame.
REQ-010 SHALL provide ports paddleLeft, paddleRight, paddleTop, paddleBottom  output  13 each  committed bounding box.
REQ-011 SHALL provide port paddleValid  output  1  last committed frame met MIN_PIXELS.
REQ-012 SHALL provide port newFrame  output  1  one-cycle pulse when a frame is committed.

Function
REQ-013 SHALL implement a two-state FSM: ACCUM (default) and COMMIT; COMMIT lasts exactly one cycle, then returns to ACCUM.
REQ-014 SHALL, in ACCUM, on pixel_valid & pixel_match with pixel_x < IMG_W and pixel_y < IMG_H, update minX/maxX/minY/maxY and increment count.
REQ-015 SHALL ignore out-of-range coordinates and pixels with pixel_match=0.
REQ-016 SHALL hold a 20-bit count that saturates at 2^20-1.
REQ-017 SHALL initialise accumulators to empty: minX=minY=13'h1FFF, maxX=maxY=0, count=0.
REQ-018 SHALL, on frame_end in ACCUM, include any qualifying pixel from that same cycle, then enter COMMIT.
REQ-019 SHALL, in COMMIT, if count >= MIN_PIXELS, load outputs Left=minX, Right=maxX, Top=minY, Bottom=maxY and set paddleValid=1; otherwise hold the box and set paddleValid=0.
REQ-020 SHALL assert newFrame for exactly the COMMIT cycle, so the box and paddleValid update on the same edge that newFrame goes high.
REQ-021 SHALL, in COMMIT, clear the accumulators and then seed them with a qualifying pixel from that cycle, so no pixel is lost.
REQ-022 SHALL ignore frame_end asserted while in COMMIT.
REQ-023 SHALL commit a frame with zero matching pixels as an invalid frame, with the box held.

Reset
REQ-024 SHALL, on reset, force the FSM to ACCUM, clear the accumulators to empty, drive all box outputs to 0, and drive paddleValid=0 and newFrame=0.
REQ-025 SHALL give reset priority over frame_end and pixel input in the same cycle; a frame in progress is discarded.

Configuration
REQ-026 SHALL, with PADDLE_SMOOTH_EN defined, commit each edge as (old+new)>>1 using a 14-bit sum, except that a commit following paddleValid=0 loads directly.
REQ-027 SHALL, without PADDLE_SMOOTH_EN, load box edges directly per REQ-019.

Structure
REQ-028 SHALL place COORD_W=13, CNT_W=20, the empty-accumulator constants and the FSM state enum in shared package paddle_pkg.
REQ-029 SHALL implement each axis min/max update in one sub-module, minmax_accum, instantiated twice (X, Y).

Verification
REQ-030 SHALL cover a basic frame: 100 matching pixels over x 300..309, y 400..409, then frame_end -> next cycle newFrame=1, box 300/309/400/409, paddleValid=1.
REQ-031 SHALL cover below threshold: 63 matching pixels then frame_end -> newFrame=1, paddleValid=0, box unchanged from the prior frame.
REQ-032 SHALL cover the boundary pixel: a matching pixel at (0,0) together with frame_end -> pixel included, Left=0, Top=0.
REQ-033 SHALL cover the COMMIT-cycle pixel: matching (50,60) during COMMIT, then 63 more pixels at (50,60), then frame_end -> paddleValid=1, box 50/50/60/60.
REQ-034 SHALL cover reset mid-frame: 40 pixels, reset, 64 pixels at x 10..17, then frame_end -> box reflects only the post-reset pixels, with no stale minX.
REQ-035 SHALL cover out of range and smoothing: pixel_x=640 ignored; with PADDLE_SMOOTH_EN, prior Left=100 and new minX=200 -> Left=150.

Source files
------------

// File: rtl/paddle_pkg.sv
// Shared definitions for the paddle bounding-box tracker.
// Holds the coordinate and counter widths, the "empty accumulator" constants,
// the FSM state type and the edge-averaging helper. The helper is only used
// when the build defines PADDLE_SMOOTH_EN.
package paddle_pkg;

  localparam int COORD_W = 13;
  localparam int CNT_W   = 20;

  // An empty accumulator has min above any real coordinate and max below it,
  // so the first qualifying pixel wins both comparisons.
  localparam logic [COORD_W-1:0] EMPTY_MIN = {COORD_W{1'b1}};
  localparam logic [COORD_W-1:0] EMPTY_MAX = {COORD_W{1'b0}};

  // The pixel counter stops here instead of wrapping back to a small value.
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {
    ACCUM  = 1'b0,
    COMMIT = 1'b1
  } state_t;

  // Average of the committed edge and the new frame's edge. The sum is one bit
  // wider than a coordinate so that the carry survives the halving.
  function automatic logic [COORD_W-1:0] smoothEdge(
    input logic [COORD_W-1:0] oldEdge,
    input logic [COORD_W-1:0] newEdge
  );
    logic [COORD_W:0] sum;
    sum = {1'b0, oldEdge} + {1'b0, newEdge};
    return sum[COORD_W:1];
  endfunction

endpackage

// File: rtl/minmax_accum.sv
// Running minimum/maximum of one coordinate axis for the paddle tracker.
// The tracker instantiates this once for X and once for Y. Besides holding the
// running extremes, the block exposes their next-cycle values. This lets the
// tracker commit a frame that includes a pixel arriving in the frame_end cycle.
module minmax_accum
  import paddle_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               update,
  input  logic [COORD_W-1:0] coord,
  output logic [COORD_W-1:0] nextMin,
  output logic [COORD_W-1:0] nextMax
);

  logic [COORD_W-1:0] minVal;
  logic [COORD_W-1:0] maxVal;

  // Next extremes: optionally restart from empty, then fold in this cycle's pixel.
  // Clearing and seeding happen in the same cycle, so a pixel arriving in the
  // commit cycle starts the next frame.
  always_comb begin
    nextMin = minVal;
    nextMax = maxVal;
    if (clear) begin
      nextMin = EMPTY_MIN;
      nextMax = EMPTY_MAX;
    end
    if (update) begin
      if (coord < nextMin) begin
        nextMin = coord;
      end
      if (coord > nextMax) begin
        nextMax = coord;
      end
    end
  end

  // Register the extremes. Reset drops them back to the empty state.
  always_ff @(posedge clk) begin
    if (reset) begin
      minVal <= EMPTY_MIN;
      maxVal <= EMPTY_MAX;
    end else begin
      minVal <= nextMin;
      maxVal <= nextMax;
    end
  end

endmodule

// File: rtl/paddle_bbox_tracker.sv
// Paddle bounding-box tracker.
// Colour-matched pixels are streamed in. The tracker accumulates their
// bounding box and pixel count over a frame. On frame_end it commits the box
// to the outputs, provided enough pixels matched.
// The FSM spends one COMMIT cycle per frame. newFrame is high for exactly that
// cycle. The outputs already hold the new box and validity while newFrame is high.
// Optional build macro: PADDLE_SMOOTH_EN. When it is defined, each committed
// edge is the average of the old and new edges. A commit that follows an
// invalid frame still loads the new edges directly.
module paddle_bbox_tracker
  import paddle_pkg::*;
#(
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int MIN_PIXELS = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pixel_valid,
  input  logic [COORD_W-1:0] pixel_x,
  input  logic [COORD_W-1:0] pixel_y,
  input  logic               pixel_match,
  input  logic               frame_end,
  output logic [COORD_W-1:0] paddleLeft,
  output logic [COORD_W-1:0] paddleRight,
  output logic [COORD_W-1:0] paddleTop,
  output logic [COORD_W-1:0] paddleBottom,
  output logic               paddleValid,
  output logic               newFrame
);

  // The limits are one bit wider than a coordinate, so an image dimension up to
  // 2^COORD_W can be compared without truncation.
  localparam logic [COORD_W:0] X_LIM   = (COORD_W+1)'(IMG_W);
  localparam logic [COORD_W:0] Y_LIM   = (COORD_W+1)'(IMG_H);
  localparam logic [CNT_W:0]   CNT_MIN = (CNT_W+1)'(MIN_PIXELS);

  state_t             state;
  logic               inCommit;
  logic               qualify;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   countBase;
  logic [CNT_W-1:0]   nextCount;
  logic               enoughPixels;
  logic [COORD_W-1:0] nextMinX;
  logic [COORD_W-1:0] nextMaxX;
  logic [COORD_W-1:0] nextMinY;
  logic [COORD_W-1:0] nextMaxY;

  assign inCommit = (state == COMMIT);

  // A pixel counts only if it is valid, matches the paddle colour and lies
  // inside the active image.
  always_comb begin
    qualify = pixel_valid & pixel_match &
              ({1'b0, pixel_x} < X_LIM) &
              ({1'b0, pixel_y} < Y_LIM);
  end

  minmax_accum xAxis (
    .clk     (clk),
    .reset   (reset),
    .clear   (inCommit),
    .update  (qualify),
    .coord   (pixel_x),
    .nextMin (nextMinX),
    .nextMax (nextMaxX)
  );

  minmax_accum yAxis (
    .clk     (clk),
    .reset   (reset),
    .clear   (inCommit),
    .update  (qualify),
    .coord   (pixel_y),
    .nextMin (nextMinY),
    .nextMax (nextMaxY)
  );

  // Next pixel count. The count restarts in the commit cycle and may be seeded
  // by that cycle's pixel. It saturates instead of wrapping, so a huge blob can
  // never look like a small one.
  always_comb begin
    countBase = inCommit ? '0 : count;
    nextCount = countBase;
    if (qualify && (countBase != CNT_MAX)) begin
      nextCount = countBase + 1'b1;
    end
    enoughPixels = ({1'b0, nextCount} >= CNT_MIN);
  end

  // Hold the running pixel count for the frame in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= nextCount;
    end
  end

  // Frame FSM with registered outputs. frame_end in ACCUM commits the frame,
  // including any pixel arriving in the same cycle, on the edge that enters
  // COMMIT. COMMIT always returns to ACCUM, so a frame_end seen there is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ACCUM;
      newFrame     <= 1'b0;
      paddleValid  <= 1'b0;
      paddleLeft   <= '0;
      paddleRight  <= '0;
      paddleTop    <= '0;
      paddleBottom <= '0;
    end else if (state == ACCUM) begin
      newFrame <= 1'b0;
      if (frame_end) begin
        state    <= COMMIT;
        newFrame <= 1'b1;
        if (enoughPixels) begin
          paddleValid <= 1'b1;
`ifdef PADDLE_SMOOTH_EN
          if (paddleValid) begin
            paddleLeft   <= smoothEdge(paddleLeft,   nextMinX);
            paddleRight  <= smoothEdge(paddleRight,  nextMaxX);
            paddleTop    <= smoothEdge(paddleTop,    nextMinY);
            paddleBottom <= smoothEdge(paddleBottom, nextMaxY);
          end else begin
            paddleLeft   <= nextMinX;
            paddleRight  <= nextMaxX;
            paddleTop    <= nextMinY;
            paddleBottom <= nextMaxY;
          end
`else
          paddleLeft   <= nextMinX;
          paddleRight  <= nextMaxX;
          paddleTop    <= nextMinY;
          paddleBottom <= nextMaxY;
`endif
        end else begin
          paddleValid <= 1'b0;
        end
      end
    end else begin
      state    <= ACCUM;
      newFrame <= 1'b0;
    end
  end

endmodule
